// File: rtl/intt_pkg.sv
// Shared types and helpers for the INTT control path: FSM states, butterfly modes, stage geometry.
package intt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } state_e;

    localparam logic [1:0] MODE_LOCAL = 2'd0;
    localparam logic [1:0] MODE_INTRA = 2'd1;
    localparam logic [1:0] MODE_CROSS = 2'd2;

    // Each core holds 2^(log_n-log_core_count) coefficients, read as pairs from the two banks.
    function automatic int words_per_stage(input int log_n, input int log_core_count);
        return 1 << (log_n - log_core_count - 1);
    endfunction

endpackage

// File: rtl/intt_ctrl_delay_line.sv
// Write-side delay line: {valid, addr, select} reappear DEPTH cycles after entry, with no stall path.
// Reset empties the line, so no stale write can fire after an abort.
module intt_ctrl_delay_line #(
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_sel,
    output logic                  out_vld,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_sel
);

    logic [DEPTH-1:0]                 vld_q;
    logic [DEPTH-1:0]                 sel_q;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            sel_q  <= '0;
            addr_q <= '0;
        end else begin
            vld_q[0]  <= in_vld;
            sel_q[0]  <= in_sel;
            addr_q[0] <= in_addr;
            for (int j = 1; j < DEPTH; j++) begin
                vld_q[j]  <= vld_q[j-1];
                sel_q[j]  <= sel_q[j-1];
                addr_q[j] <= addr_q[j-1];
            end
        end
    end

    assign out_vld  = vld_q[DEPTH-1];
    assign out_sel  = sel_q[DEPTH-1];
    assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/intt_controller.sv
// Stage sequencer for intt_core: issues reads, replays them as writes PIPE_LAT cycles later, ping-pongs banks.
// One stage = WORDS reads + PIPE_LAT drain + 1 turnaround; start is ignored unless idle.
module intt_controller
    import intt_pkg::*;
#(
    parameter int LOG_N          = 12,
    parameter int LOG_CORE_COUNT = 4,
    parameter int ADDR_WIDTH     = 9,
    parameter int PIPE_LAT       = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            log_m,
    output logic [9:0]            i,
    output logic [1:0]            mode,
    output logic [ADDR_WIDTH-1:0] upper_read_address,
    output logic [ADDR_WIDTH-1:0] lower_read_address,
    output logic                  upper_write_enable,
    output logic                  lower_write_enable,
    output logic [ADDR_WIDTH-1:0] upper_write_address,
    output logic [ADDR_WIDTH-1:0] lower_write_address,
    output logic                  read_select,
    output logic                  write_select,
    output logic                  input_select
);

    localparam int                  WORDS     = words_per_stage(LOG_N, LOG_CORE_COUNT);
    localparam int                  DW        = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [ADDR_WIDTH-1:0] K_LAST  = ADDR_WIDTH'(WORDS - 1);
    localparam logic [DW-1:0]       D_LAST    = DW'(PIPE_LAT - 1);
    localparam logic [3:0]          LOG_M_TOP = 4'(LOG_N);
    localparam logic [3:0]          LOG_M_LOC = 4'(LOG_CORE_COUNT + 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   k_q, k_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic [3:0]              log_m_q, log_m_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic                    wr_sel_q;
    logic [3:0]              i_shift;
    logic                    dl_vld;
    logic                    dl_sel;
    logic [ADDR_WIDTH-1:0]   dl_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            drain_q   <= '0;
            log_m_q   <= LOG_M_TOP;
            wr_addr_q <= '0;
            wr_sel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            log_m_q <= log_m_d;
            if (dl_vld) begin
                wr_addr_q <= dl_addr;
                wr_sel_q  <= dl_sel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drain_d = drain_q;
        log_m_d = log_m_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                    log_m_d = LOG_M_TOP;
                end
            end
            ST_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == D_LAST) state_d = ST_NEXT;
                else                   drain_d = drain_q + 1'b1;
            end
            ST_NEXT: begin
                k_d = '0;
                if (log_m_q == 4'd1) begin
                    state_d = ST_DONE;
                    log_m_d = LOG_M_TOP;
                end else begin
                    state_d = ST_RUN;
                    log_m_d = log_m_q - 4'd1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (log_m_q == LOG_M_TOP)     mode = MODE_LOCAL;
        else if (log_m_q > LOG_M_LOC) mode = MODE_INTRA;
        else                          mode = MODE_CROSS;
        i_shift = (log_m_q > LOG_M_LOC) ? (log_m_q - LOG_M_LOC) : 4'd0;
    end

    assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_NEXT);
    assign done         = (state_q == ST_DONE);
    assign log_m        = log_m_q;
    assign i            = 10'(k_q >> i_shift);
    assign input_select = (mode == MODE_CROSS);
    // Stage index parity: (LOG_N - log_m)[0] reduces to an XOR of the two LSBs.
    assign read_select  = LOG_M_TOP[0] ^ log_m_q[0];

    assign upper_read_address = k_q;
    assign lower_read_address = k_q;

    intt_ctrl_delay_line #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (PIPE_LAT)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (state_q == ST_RUN),
        .in_addr  (k_q),
        .in_sel   (~read_select),
        .out_vld  (dl_vld),
        .out_addr (dl_addr),
        .out_sel  (dl_sel)
    );

    assign upper_write_enable  = dl_vld;
    assign lower_write_enable  = dl_vld;
    assign upper_write_address = dl_vld ? dl_addr : wr_addr_q;
    assign lower_write_address = dl_vld ? dl_addr : wr_addr_q;
    assign write_select        = dl_vld ? dl_sel  : wr_sel_q;

endmodule

// File: tb/tb_intt_controller.sv
// Bench for intt_controller in a small configuration (LOG_N=6, 4 cores, PIPE_LAT=3).
module tb_intt_controller;

    localparam int LN    = 6;
    localparam int LCC   = 2;
    localparam int AW    = 9;
    localparam int PL    = 3;
    localparam int WORDS = 1 << (LN - LCC - 1);
    localparam int STAGE = WORDS + PL + 1;
    localparam int TOTAL = LN * STAGE;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy, done;
    logic [3:0]    log_m;
    logic [9:0]    i;
    logic [1:0]    mode;
    logic [AW-1:0] ura, lra, uwa, lwa;
    logic          uwe, lwe;
    logic          rsel, wsel, isel;

    int n_tests = 0;
    int n_fail  = 0;

    intt_controller #(
        .LOG_N          (LN),
        .LOG_CORE_COUNT (LCC),
        .ADDR_WIDTH     (AW),
        .PIPE_LAT       (PL)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .busy                (busy),
        .done                (done),
        .log_m               (log_m),
        .i                   (i),
        .mode                (mode),
        .upper_read_address  (ura),
        .lower_read_address  (lra),
        .upper_write_enable  (uwe),
        .lower_write_enable  (lwe),
        .upper_write_address (uwa),
        .lower_write_address (lwa),
        .read_select         (rsel),
        .write_select        (wsel),
        .input_select        (isel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input bit after_reset);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_log_m", int'(log_m), LN);
        chk("idle_mode", int'(mode), 0);
        chk("idle_i", int'(i), 0);
        chk("idle_rsel", int'(rsel), 0);
        chk("idle_isel", int'(isel), 0);
        chk("idle_uwe", int'(uwe), 0);
        chk("idle_lwe", int'(lwe), 0);
        if (after_reset) begin
            chk("rst_ura", int'(ura), 0);
            chk("rst_lra", int'(lra), 0);
            chk("rst_uwa", int'(uwa), 0);
            chk("rst_lwa", int'(lwa), 0);
            chk("rst_wsel", int'(wsel), 0);
        end
    endtask

    // Reference: t counts cycles since start was sampled; stage geometry from plain arithmetic.
    task automatic check_run_cycle(input int t);
        int stage, pos, lm, emode, sh, k;
        bit ewe;
        if (t >= TOTAL) begin
            chk("done_pulse", int'(done), 1);
            chk("done_busy", int'(busy), 0);
            chk("done_log_m", int'(log_m), LN);
            chk("done_mode", int'(mode), 0);
            chk("done_rsel", int'(rsel), 0);
            chk("done_we", int'(uwe), 0);
            return;
        end
        stage = t / STAGE;
        pos   = t % STAGE;
        lm    = LN - stage;
        emode = (lm == LN) ? 0 : ((lm > LCC + 1) ? 1 : 2);
        sh    = (lm - LCC - 1 > 0) ? (lm - LCC - 1) : 0;
        k     = (pos < WORDS) ? pos : WORDS - 1;
        ewe   = (pos >= PL) && (pos < WORDS + PL);
        chk("run_busy", int'(busy), 1);
        chk("run_done", int'(done), 0);
        chk("log_m", int'(log_m), lm);
        chk("mode", int'(mode), emode);
        chk("input_select", int'(isel), (emode == 2) ? 1 : 0);
        chk("read_select", int'(rsel), stage % 2);
        if (pos < WORDS + PL) begin
            chk("upper_raddr", int'(ura), k);
            chk("lower_raddr", int'(lra), k);
        end
        if (pos < WORDS) chk("i", int'(i), k >> sh);
        chk("upper_we", int'(uwe), int'(ewe));
        chk("lower_we", int'(lwe), int'(ewe));
        if (ewe) begin
            chk("upper_waddr", int'(uwa), pos - PL);
            chk("lower_waddr", int'(lwa), pos - PL);
            chk("write_select", int'(wsel), 1 - (stage % 2));
        end
    endtask

    task automatic run_full(input int run_id);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= TOTAL; t++) begin
            check_run_cycle(t);
            start = (run_id == 0 && t == 30) || (run_id == 1 && t == TOTAL) ||
                    ($urandom_range(0, 19) == 0);
            tick();
        end
        start = 1'b0;
        check_idle(1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        check_idle(1'b1);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check_idle(1'b1);
        end

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(1, 6)) begin
                tick();
                check_idle(1'b0);
            end
            run_full(r);
        end

        // Abort in the second stage's drain while writes are still in flight.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < STAGE + WORDS + 1; t++) begin
            check_run_cycle(t);
            tick();
        end
        check_run_cycle(STAGE + WORDS + 1);
        #2 rst_n = 1'b0;
        #1 check_idle(1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check_idle(1'b1);
        end
        #3 rst_n = 1'b1;
        tick();
        check_idle(1'b1);
        run_full(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intt_controller.md
Name: intt_controller

Overview:
- Control-side counterpart of intt_core: the sequencer that drives intt_core's control inputs.
- Drives log_m, i, mode, both banks' read/write addresses and write enables, and the ping-pong bank selects, stage by stage, for a full inverse NTT.
- One instance per core group; its outputs fan out to all intt_core instances of that group.
- Start/busy/done handshake toward the top-level scheduler.

Parameters:
- LOG_N, 12, log2 of polynomial length; first stage log_m.
- LOG_CORE_COUNT, 4, log2 of number of cores sharing the schedule.
- ADDR_WIDTH, 9, bank address width.
- PIPE_LAT, 6, cycles from read address issued to result valid at core write port.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a full INTT; ignored while busy.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final stage's last write.
- log_m  out  4  current stage, LOG_N down to 1.
- i  out  10  twiddle group index for current read.
- mode  out  2  butterfly mode for current stage.
- upper_read_address  out  ADDR_WIDTH  upper bank read address.
- lower_read_address  out  ADDR_WIDTH  lower bank read address.
- upper_write_enable  out  1  upper bank write strobe.
- lower_write_enable  out  1  lower bank write strobe.
- upper_write_address  out  ADDR_WIDTH  upper bank write address.
- lower_write_address  out  ADDR_WIDTH  lower bank write address.
- read_select  out  1  bank set read this stage.
- write_select  out  1  bank set written by the delayed writes.
- input_select  out  1  1 = core takes direct (cross-core) inputs.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n asynchronous, active-low: on assertion all state clears immediately, including mid-run.
- Reset values:
  - busy=0, done=0, log_m=LOG_N, i=0, mode=0.
  - All addresses 0, both write enables 0, read_select=0, write_select=0, input_select=0.
  - FSM in IDLE, delay line empty.
- Stage geometry:
  - WORDS = 2^(LOG_N-LOG_CORE_COUNT-1) words per stage.
  - Stage index s = LOG_N - log_m.
- FSM states IDLE, RUN, DRAIN, NEXT, DONE:
  - IDLE: start=1 -> RUN; k=0, log_m=LOG_N, busy=1.
  - RUN, each cycle:
    - upper_read_address = lower_read_address = k.
    - i = k >> max(log_m-LOG_CORE_COUNT-1, 0), zero-extended to 10 bits.
    - Push {valid=1, addr=k, write_select} into the delay line.
    - k increments; after k=WORDS-1 -> DRAIN.
  - DRAIN: PIPE_LAT cycles, pushing valid=0; read addresses hold last value.
  - NEXT: one cycle.
    - log_m==1 -> DONE.
    - Otherwise log_m decrements, k=0, read_select toggles -> RUN.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
    - log_m, read_select and mode return to reset values.
- Mode per stage:
  - log_m==LOG_N -> 0.
  - log_m > LOG_CORE_COUNT+1 -> 1.
  - Otherwise -> 2.
  - input_select = (mode==2).
- Bank selects:
  - read_select = s[0].
  - Write-side select = ~read_select at issue time, carried through the delay line.
- Write side, delay line output PIPE_LAT cycles later:
  - upper_write_enable = lower_write_enable = valid.
  - upper_write_address = lower_write_address = delayed addr.
  - write_select = delayed select.
  - Write address holds its last value when valid=0.
- Ordering: DRAIN length guarantees every write of stage s lands before stage s+1's first read. No read/write overlap across stages.
- Cycle counts:
  - Per stage: WORDS + PIPE_LAT + 1 cycles.
  - done asserts LOG_N*(WORDS+PIPE_LAT+1) cycles after the cycle start is sampled.
- start during busy: ignored, no queueing.
- start in the DONE cycle: ignored; a new start is accepted from IDLE onward.

Decomposition:
- Shared package intt_pkg:
  - FSM state enum.
  - Mode constants MODE_LOCAL=0, MODE_INTRA=1, MODE_CROSS=2.
  - Function computing words per stage from LOG_N and LOG_CORE_COUNT.
- One sub-module: intt_ctrl_delay_line.
  - PIPE_LAT-deep shift register of {valid, addr, select}.
  - Async active-low reset clears all valid bits.

Test Plan:
- Reset/idle: hold rst_n=0, then release with no start. All outputs at reset values; log_m=LOG_N; busy=0 for 20 cycles.
- Full run, LOG_N=6, LOG_CORE_COUNT=2, PIPE_LAT=3 (WORDS=8, 12 cycles/stage):
  - Pulse start. busy rises next cycle.
  - log_m sequence 6,5,4,3,2,1; mode sequence 0,1,1,2,2,2; input_select=1 only for log_m 3..1.
  - done pulses exactly 72 cycles after start; busy falls with done.
- Addresses and i, same config:
  - Stage log_m=6: read addresses 0..7, i=0 throughout.
  - Stage log_m=3: i=0..7 tracking the address.
  - Write enable with addresses 0..7 appears 3 cycles behind reads; 8 writes per stage.
- Ping-pong: read_select = 0,1,0,1,0,1 across stages. Every asserted write enable carries write_select = ~read_select of its issuing stage, including the last drain write.
- start re-pulsed mid-run at cycle 30: no effect; done still at cycle 72. A second start after done begins a fresh run identical to the first.
- rst_n asserted mid-DRAIN of stage 2: outputs return to reset values immediately; no further write enables. After release, a new start completes normally in 72 cycles.
